jtcop_obj_buffer: RTL and testbench

Double-buffered object line buffer feeding the colour mixer's `obj_pxl` input (the "MCOL" bus). The object drawer renders line N+1 into one bank while the other bank is scanned out at pixel rate for line N. Each scanned location is erased right after it is read. Banks swap at the start of every horizontal blank. Transparent pixels are skipped on write, and an optional first-drawn-wins priority check is available.

---
 rtl/jtcop_pkg.sv | 13 +
 rtl/jtcop_objbuf_wr.sv | 80 ++++++++
 rtl/jtframe_dual_ram.sv | 24 ++
 rtl/jtcop_obj_buffer.sv | 123 ++++++++++++
 tb/tb_jtcop_obj_buffer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/jtcop_pkg.sv
// Shared definitions for the jtcop object line buffer: default geometry and the
// transparency test used by the draw-side filter.
package jtcop_pkg;

  localparam int OBJBUF_AW = 8;
  localparam int OBJ_PW    = 8;

  // A pixel whose colour nibble is zero is transparent and never stored.
  function automatic logic obj_transparent(input logic [OBJ_PW-1:0] pxl);
    return ~|pxl[3:0];
  endfunction

endpackage

// File: rtl/jtcop_objbuf_wr.sv
// Draw-side write path: drops transparent/off-screen pixels and, when
// JTCOP_OBJBUF_PRIO_EN is defined, performs a first-drawn-wins read-modify-write.
module jtcop_objbuf_wr
  import jtcop_pkg::*;
#(
  parameter int AW = OBJBUF_AW,
  parameter int PW = OBJ_PW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          buf_we_i,
  input  logic [AW:0]   buf_addr_i,
  input  logic [PW-1:0] buf_din_i,
  input  logic          draw_bank_i,
  input  logic [PW-1:0] rd_data_i,
  output logic [AW-1:0] rd_addr_o,
  output logic          rd_bank_o,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic          wr_bank_o,
  output logic [PW-1:0] wr_data_o
);

  logic accept;
  assign accept = buf_we_i & ~buf_addr_i[AW] & ~obj_transparent(buf_din_i);

`ifdef JTCOP_OBJBUF_PRIO_EN
  logic          s1_valid_q, s2_valid_q;
  logic [AW-1:0] s1_addr_q, s2_addr_q;
  logic          s1_bank_q, s2_bank_q;
  logic [PW-1:0] s1_data_q, s2_data_q;
  logic          fwd_hit;
  logic [PW-1:0] stored;

  // The RAM read for stage 1 happened in the same edge as the previous write,
  // so it returned stale data; take the just-written pixel instead.
  assign fwd_hit   = s2_valid_q && (s2_addr_q == s1_addr_q) && (s2_bank_q == s1_bank_q);
  assign stored    = fwd_hit ? s2_data_q : rd_data_i;

  assign rd_addr_o = buf_addr_i[AW-1:0];
  assign rd_bank_o = s1_bank_q;
  assign wr_en_o   = s1_valid_q & obj_transparent(stored);
  assign wr_addr_o = s1_addr_q;
  assign wr_bank_o = s1_bank_q;
  assign wr_data_o = s1_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_bank_q  <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_bank_q  <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      s1_addr_q  <= buf_addr_i[AW-1:0];
      s1_bank_q  <= draw_bank_i;
      s1_data_q  <= buf_din_i;
      s2_valid_q <= wr_en_o;
      s2_addr_q  <= s1_addr_q;
      s2_bank_q  <= s1_bank_q;
      s2_data_q  <= s1_data_q;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst_n, rd_data_i};

  assign rd_addr_o = '0;
  assign rd_bank_o = draw_bank_i;
  assign wr_en_o   = accept;
  assign wr_addr_o = buf_addr_i[AW-1:0];
  assign wr_bank_o = draw_bank_i;
  assign wr_data_o = buf_din_i;
`endif

endmodule

// File: rtl/jtframe_dual_ram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port.
// A read and a write to the same address in one cycle return the old data.
module jtframe_dual_ram #(
  parameter int aw = 8,
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [aw-1:0] wr_addr_i,
  input  logic [dw-1:0] data_i,
  input  logic [aw-1:0] rd_addr_i,
  output logic [dw-1:0] q_o
);

  logic [dw-1:0] mem [2**aw];

  // NOTE: the array has no reset; a reset loop over memory cannot map onto block RAM.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (we_i) mem[wr_addr_i] <= data_i;
    q_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/jtcop_obj_buffer.sv
// Double-buffered object line buffer feeding the colour mixer; banks swap at each
// LHBL falling edge. Optional first-drawn-wins priority via JTCOP_OBJBUF_PRIO_EN.
module jtcop_obj_buffer
  import jtcop_pkg::*;
#(
  parameter int AW = OBJBUF_AW,
  parameter int PW = OBJ_PW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic [AW-1:0] hdump,
  input  logic          flip,
  output logic          line_start,
  output logic          draw_bank,
  input  logic          buf_we,
  input  logic [AW:0]   buf_addr,
  input  logic [PW-1:0] buf_din,
  output logic [PW-1:0] obj_pxl
);

  logic          lhbl_q, lhbl_fall;
  logic          draw_bank_q, draw_bank_d;
  logic          line_start_q;
  logic          rd_valid_q, rd_bank_q;
  logic [AW-1:0] rd_addr_q, scan_addr;
  logic [PW-1:0] obj_pxl_q, obj_pxl_d;

  logic [AW-1:0] dr_rd_addr, dr_wr_addr;
  logic          dr_rd_bank, dr_we, dr_wr_bank;
  logic [PW-1:0] dr_wr_data, dr_rd_data;

  logic          ram_we      [2];
  logic [AW-1:0] ram_wr_addr [2];
  logic [AW-1:0] ram_rd_addr [2];
  logic [PW-1:0] ram_din     [2];
  logic [PW-1:0] ram_q       [2];

  assign scan_addr   = flip ? ~hdump : hdump;
  assign lhbl_fall   = lhbl_q & ~LHBL;
  assign draw_bank_d = draw_bank_q ^ lhbl_fall;
  assign dr_rd_data  = ram_q[dr_rd_bank];

  jtcop_objbuf_wr #(.AW(AW), .PW(PW)) u_wr (
    .clk         (clk),
    .rst_n       (rst_n),
    .buf_we_i    (buf_we),
    .buf_addr_i  (buf_addr),
    .buf_din_i   (buf_din),
    .draw_bank_i (draw_bank_q),
    .rd_data_i   (dr_rd_data),
    .rd_addr_o   (dr_rd_addr),
    .rd_bank_o   (dr_rd_bank),
    .wr_en_o     (dr_we),
    .wr_addr_o   (dr_wr_addr),
    .wr_bank_o   (dr_wr_bank),
    .wr_data_o   (dr_wr_data)
  );

  // Role mux. The erase is tagged with the bank it was read from, so the last
  // visible pixel still clears the old scan bank after a swap.
  // NOTE: every output gets a value on every path, so no latches are inferred.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      ram_rd_addr[b] = (draw_bank_q != 1'(b)) ? scan_addr : dr_rd_addr;
      if (rd_valid_q && rd_bank_q == 1'(b)) begin
        ram_we[b]      = 1'b1;
        ram_wr_addr[b] = rd_addr_q;
        ram_din[b]     = '0;
      end else begin
        ram_we[b]      = dr_we && (dr_wr_bank == 1'(b));
        ram_wr_addr[b] = dr_wr_addr;
        ram_din[b]     = dr_wr_data;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    jtframe_dual_ram #(.aw(AW), .dw(PW)) u_ram (
      .clk       (clk),
      .we_i      (ram_we[g]),
      .wr_addr_i (ram_wr_addr[g]),
      .data_i    (ram_din[g]),
      .rd_addr_i (ram_rd_addr[g]),
      .q_o       (ram_q[g])
    );
  end

  always_comb begin
    obj_pxl_d = obj_pxl_q;
    if (rd_valid_q)             obj_pxl_d = ram_q[rd_bank_q];
    else if (pxl_cen && !LHBL)  obj_pxl_d = '0;
  end

  // lhbl_q resets low so an LHBL held low through reset is not taken as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lhbl_q       <= 1'b0;
      draw_bank_q  <= 1'b0;
      line_start_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_bank_q    <= 1'b0;
      rd_addr_q    <= '0;
      obj_pxl_q    <= '0;
    end else begin
      lhbl_q       <= LHBL;
      draw_bank_q  <= draw_bank_d;
      line_start_q <= lhbl_fall;
      rd_valid_q   <= pxl_cen & LHBL;
      if (pxl_cen) begin
        rd_addr_q <= scan_addr;
        rd_bank_q <= ~draw_bank_q;
      end
      obj_pxl_q    <= obj_pxl_d;
    end
  end

  assign obj_pxl    = obj_pxl_q;
  assign draw_bank  = draw_bank_q;
  assign line_start = line_start_q;

endmodule

// File: tb/tb_jtcop_obj_buffer.sv
// Directed bench for jtcop_obj_buffer; expected pixels follow the build's
// JTCOP_OBJBUF_PRIO_EN setting.
module tb_jtcop_obj_buffer;
  import jtcop_pkg::*;

  localparam int AW = OBJBUF_AW;
  localparam int PW = OBJ_PW;
`ifdef JTCOP_OBJBUF_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, pxl_cen, LHBL, flip, buf_we;
  logic [AW-1:0] hdump;
  logic [AW:0]   buf_addr;
  logic [PW-1:0] buf_din;
  logic          line_start, draw_bank;
  logic [PW-1:0] obj_pxl;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            ls_cnt = 0;
  int            exp_ls = 0;
  logic          exp_bank;
  logic [PW-1:0] exp_pxl;
  logic [PW-1:0] v, acc;

  always #5 clk = ~clk;

  jtcop_obj_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pxl_cen    (pxl_cen),
    .LHBL       (LHBL),
    .hdump      (hdump),
    .flip       (flip),
    .line_start (line_start),
    .draw_bank  (draw_bank),
    .buf_we     (buf_we),
    .buf_addr   (buf_addr),
    .buf_din    (buf_din),
    .obj_pxl    (obj_pxl)
  );

  always @(negedge clk) if (line_start) ls_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic scan(input logic [AW-1:0] col, input logic [PW-1:0] exp, input string tag);
    @(negedge clk); hdump = col; pxl_cen = 1'b1;
    @(negedge clk); pxl_cen = 1'b0;
    check({tag, "_hold"}, 32'(obj_pxl), 32'(exp_pxl));
    @(negedge clk);
    check(tag, 32'(obj_pxl), 32'(exp));
    exp_pxl = exp;
  endtask

  task automatic scan_quiet(input logic [AW-1:0] col, output logic [PW-1:0] val);
    @(negedge clk); hdump = col; pxl_cen = 1'b1;
    @(negedge clk); pxl_cen = 1'b0;
    @(negedge clk); val = obj_pxl;
  endtask

  task automatic wr(input logic [AW:0] a, input logic [PW-1:0] d);
    @(negedge clk); buf_we = 1'b1; buf_addr = a; buf_din = d;
    @(negedge clk); buf_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic new_line();
    @(negedge clk); LHBL = 1'b0; exp_bank = ~exp_bank; exp_ls++;
    @(negedge clk);
    check("line_start", 32'(line_start), 32'd1);
    check("draw_bank", 32'(draw_bank), 32'(exp_bank));
    @(negedge clk);
    check("line_start_end", 32'(line_start), 32'd0);
    pxl_cen = 1'b1;
    @(negedge clk); pxl_cen = 1'b0;
    @(negedge clk);
    check("blank_zero", 32'(obj_pxl), 32'd0);
    check("ls_count", 32'(ls_cnt), 32'(exp_ls));
    exp_pxl = '0;
    @(negedge clk); LHBL = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; pxl_cen = 1'b0; LHBL = 1'b1; flip = 1'b0; buf_we = 1'b0;
    buf_addr = '0; buf_din = '0; hdump = '0;
    exp_bank = 1'b0; exp_pxl = '0;
    #12;
    check("rst_obj_pxl", 32'(obj_pxl), 32'd0);
    check("rst_draw_bank", 32'(draw_bank), 32'd0);
    check("rst_line_start", 32'(line_start), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Flush power-up contents from both banks.
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < 256; c++) scan_quiet(AW'(c), v);
      new_line();
    end

    // Basic draw, display and erase.
    wr(9'h010, 8'h35);
    new_line();
    scan(8'h10, 8'h35, "t1_pix");
    scan(8'h11, 8'h00, "t1_empty");
    new_line();
    new_line();
    scan(8'h10, 8'h00, "t1_erased");

    // Transparent and off-screen writes are dropped.
    wr(9'h010, 8'h70);
    wr(9'h110, 8'h5A);
    new_line();
    scan(8'h10, 8'h00, "t2_transp");
    acc = '0;
    for (int c = 0; c < 256; c++) begin
      scan_quiet(AW'(c), v);
      acc = acc | v;
    end
    check("t2_all_zero", 32'(acc), 32'd0);
    exp_pxl = '0;

    // Flipped scan-out.
    wr(9'h0FE, 8'h21);
    new_line();
    flip = 1'b1;
    scan(8'h01, 8'h21, "t3_flip");
    scan(8'hFE, 8'h00, "t3_flip_other");
    flip = 1'b0;

    // Priority: back-to-back, spaced, and transparent-then-opaque.
    @(negedge clk); buf_we = 1'b1; buf_addr = 9'h020; buf_din = 8'h41;
    @(negedge clk); buf_din = 8'h52;
    @(negedge clk); buf_we = 1'b0;
    repeat (2) @(negedge clk);
    wr(9'h030, 8'h13);
    wr(9'h030, 8'h24);
    wr(9'h031, 8'h70);
    wr(9'h031, 8'h15);
    new_line();
    scan(8'h20, PRIO ? 8'h41 : 8'h52, "t4_b2b");
    scan(8'h30, PRIO ? 8'h13 : 8'h24, "t4_spaced");
    scan(8'h31, 8'h15, "t4_over_transp");

    // Writes straddling the swap.
    @(negedge clk); buf_we = 1'b1; buf_addr = 9'h040; buf_din = 8'h66;
    @(negedge clk); buf_we = 1'b0; LHBL = 1'b0; exp_bank = ~exp_bank; exp_ls++;
    @(negedge clk);
    check("t5_line_start", 32'(line_start), 32'd1);
    check("t5_draw_bank", 32'(draw_bank), 32'(exp_bank));
    buf_we = 1'b1; buf_addr = 9'h041; buf_din = 8'h77;
    @(negedge clk); buf_we = 1'b0;
    check("t5_ls_end", 32'(line_start), 32'd0);
    repeat (2) @(negedge clk);
    check("t5_ls_count", 32'(ls_cnt), 32'(exp_ls));
    LHBL = 1'b1;
    @(negedge clk);
    scan(8'h40, 8'h66, "t5_old_bank");
    scan(8'h41, 8'h00, "t5_new_hidden");
    new_line();
    scan(8'h41, 8'h77, "t5_new_bank");

    // Reset in the middle of a swap, then release with LHBL held low.
    @(negedge clk); LHBL = 1'b0;
    @(posedge clk); #2;
    check("t6_ls_pre", 32'(line_start), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_pxl", 32'(obj_pxl), 32'd0);
    check("t6_rst_bank", 32'(draw_bank), 32'd0);
    check("t6_rst_ls", 32'(line_start), 32'd0);
    exp_bank = 1'b0; exp_pxl = '0;
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_no_swap", 32'(draw_bank), 32'd0);
    check("t6_ls_count", 32'(ls_cnt), 32'(exp_ls));
    LHBL = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_still_bank0", 32'(draw_bank), 32'd0);
    wr(9'h050, 8'h5C);
    new_line();
    scan(8'h50, 8'h5C, "t6_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
